// File: rtl/pattern_gen.sv
// ---------------------------------------------------------------------------
// pattern_gen
//   Stimulus source that emits a valid/ready stream of DATA_W-bit words for a
//   programmed number of beats. The word sequence follows one of four modes:
//   increment, rotate-left, Galois LFSR, or constant.
//
//   Build option: PATTERN_GEN_LFSR_EN
//     defined   - mode 2 is a Galois LFSR using LFSR_POLY; seed 0 becomes 1.
//     undefined - LFSR logic is absent; mode 2 behaves as increment and the
//                 seed is used unaltered.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle run request, honoured only in IDLE
//   i_mode       pattern select: 0 inc, 1 rotl, 2 LFSR, 3 constant
//   i_seed       first data word of the run
//   i_len        number of beats to emit
//   o_out_data   current word
//   o_out_valid  o_out_data is valid
//   i_out_ready  consumer accepts the word this cycle
//   o_busy       high while in RUN or DONE
//   o_done       one-cycle pulse at end of run
//   o_count      beats accepted in the current/last run
//
// State table
//   IDLE | waiting for start; count holds the last run's total
//   RUN  | presenting words, advancing on each accepted beat
//   DONE | single-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module pattern_gen #(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [LEN_W-1:0]  i_len,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;

    logic              w_beat;
    logic [LEN_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_seed_init;
    logic [DATA_W-1:0] w_data_nxt;

    function automatic logic [DATA_W-1:0] f_next(input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] v;
        v = d;
        case (m)
            2'd0: v = d + 1'b1;
            2'd1: v = {d[DATA_W-2:0], d[DATA_W-1]};
`ifdef PATTERN_GEN_LFSR_EN
            2'd2: v = d[0] ? ((d >> 1) ^ LFSR_POLY) : (d >> 1);
`else
            2'd2: v = d + 1'b1;
`endif
            default: v = d;
        endcase
        return v;
    endfunction

    // An all-zero LFSR state would lock up, so the seed is nudged to 1.
`ifdef PATTERN_GEN_LFSR_EN
    assign w_seed_init = ((i_mode == 2'd2) && (i_seed == '0)) ?
                         {{(DATA_W-1){1'b0}}, 1'b1} : i_seed;
`else
    assign w_seed_init = i_seed;
`endif

    // Valid is decoded purely from state, so ready never feeds back into it.
    assign o_out_valid = (r_state == S_RUN);
    assign w_beat      = o_out_valid & i_out_ready;
    assign w_count_nxt = r_count + 1'b1;
    assign w_data_nxt  = f_next(r_mode, r_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_len   <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode  <= i_mode;
                        r_len   <= i_len;
                        r_count <= '0;
                        r_data  <= w_seed_init;
                        r_state <= (i_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_count <= w_count_nxt;
                        r_data  <= w_data_nxt;
                        if (w_count_nxt == r_len) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_out_data = r_data;
    assign o_busy     = (r_state == S_RUN) || (r_state == S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_count    = r_count;

endmodule

// File: tb/tb_pattern_gen.sv
module tb_pattern_gen;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [7:0]  i_seed;
    logic [15:0] i_len;
    logic [7:0]  o_out_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;

    int n_checks = 0;
    int n_errors = 0;

    pattern_gen #(.DATA_W(8), .LEN_W(16), .LFSR_POLY(8'hB8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_seed      (i_seed),
        .i_len       (i_len),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_count     (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Holds start for one cycle; returns in the first cycle after acceptance.
    task automatic do_start(input logic [1:0] m, input logic [7:0] s, input logic [15:0] l);
        i_start = 1'b1;
        i_mode  = m;
        i_seed  = s;
        i_len   = l;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0; i_mode = 2'd0; i_seed = 8'h00; i_len = 16'd0; i_out_ready = 1'b0;
        repeat (3) cyc();
        i_rst_n = 1'b1;
        cyc();
        n_checks++;
        if ({o_out_data, o_out_valid, o_busy, o_done, o_count} !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_state: data=%h valid=%b busy=%b done=%b count=%0d, required all 0",
                     o_out_data, o_out_valid, o_busy, o_done, o_count);
        end
        // Abort a run after 3 beats.
        i_out_ready = 1'b1;
        do_start(2'd0, 8'h10, 16'd10);
        repeat (3) cyc();
        n_checks++;
        if (o_count !== 16'd3 || o_out_data !== 8'h13) begin
            n_errors++;
            $display("FAIL pre_abort: count=%0d data=%h, required 3 / 13", o_count, o_out_data);
        end
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_out_data, o_out_valid, o_busy, o_done, o_count} !== 27'd0) begin
            n_errors++;
            $display("FAIL midrun_reset: data=%h valid=%b busy=%b done=%b count=%0d, required all 0",
                     o_out_data, o_out_valid, o_busy, o_done, o_count);
        end
        cyc();
        cyc();
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset_idle[%0d]: done=%b busy=%b valid=%b, required 0/0/0",
                         k, o_done, o_busy, o_out_valid);
            end
        end
        // Idle after release: a fresh start is accepted.
        do_start(2'd3, 8'h77, 16'd1);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h77) begin
            n_errors++;
            $display("FAIL restart_after_reset: valid=%b data=%h, required 1 / 77", o_out_valid, o_out_data);
        end
        repeat (3) cyc();
    endtask

    task automatic test_increment();
        logic [7:0] exp_d [4];
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        i_out_ready = 1'b1;
        do_start(2'd0, 8'hFE, 16'd4);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (o_out_valid !== 1'b1 || o_out_data !== exp_d[k] || o_done !== 1'b0) begin
                n_errors++;
                $display("FAIL inc_beat[%0d]: valid=%b data=%h done=%b, required 1 / %h / 0",
                         k, o_out_valid, o_out_data, o_done, exp_d[k]);
            end
            cyc();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_out_valid !== 1'b0 || o_count !== 16'd4) begin
            n_errors++;
            $display("FAIL inc_done: done=%b busy=%b valid=%b count=%0d, required 1/1/0/4",
                     o_done, o_busy, o_out_valid, o_count);
        end
        cyc();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL inc_after_done: done=%b busy=%b, required 0/0", o_done, o_busy);
        end
        repeat (2) cyc();
        n_checks++;
        if (o_count !== 16'd4) begin
            n_errors++;
            $display("FAIL inc_count_hold: count=%0d, required 4", o_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  exp_d [5];
        logic        rdy   [5];
        logic [15:0] exp_c [5];
        exp_d = '{8'h81, 8'h03, 8'h03, 8'h03, 8'h06};
        rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_c = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
        i_out_ready = 1'b0;
        do_start(2'd1, 8'h81, 16'd3);
        for (int k = 0; k < 5; k++) begin
            i_out_ready = rdy[k];
            #1;
            n_checks++;
            if (o_out_valid !== 1'b1 || o_out_data !== exp_d[k] || o_count !== exp_c[k]) begin
                n_errors++;
                $display("FAIL bp_cycle[%0d]: valid=%b data=%h count=%0d, required 1 / %h / %0d",
                         k, o_out_valid, o_out_data, o_count, exp_d[k], exp_c[k]);
            end
            cyc();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_out_valid !== 1'b0 || o_count !== 16'd3) begin
            n_errors++;
            $display("FAIL bp_done: done=%b valid=%b count=%0d, required 1/0/3",
                     o_done, o_out_valid, o_count);
        end
        cyc();
    endtask

    task automatic test_lfsr();
        logic [7:0] exp_d [6];
`ifdef PATTERN_GEN_LFSR_EN
        exp_d = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
`else
        exp_d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
        i_out_ready = 1'b1;
        do_start(2'd2, 8'h00, 16'd6);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (o_out_valid !== 1'b1 || o_out_data !== exp_d[k]) begin
                n_errors++;
                $display("FAIL lfsr_beat[%0d]: valid=%b data=%h, required 1 / %h",
                         k, o_out_valid, o_out_data, exp_d[k]);
            end
            cyc();
        end
        n_checks++;
        if (o_done !== 1'b1 || o_count !== 16'd6) begin
            n_errors++;
            $display("FAIL lfsr_done: done=%b count=%0d, required 1/6", o_done, o_count);
        end
        cyc();
    endtask

    task automatic test_zero_len();
        i_out_ready = 1'b1;
        do_start(2'd0, 8'h55, 16'd0);
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_out_valid !== 1'b0 || o_count !== 16'd0) begin
            n_errors++;
            $display("FAIL zero_len_done: done=%b busy=%b valid=%b count=%0d, required 1/1/0/0",
                     o_done, o_busy, o_out_valid, o_count);
        end
        cyc();
        n_checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_len_after: done=%b busy=%b valid=%b, required 0/0/0",
                     o_done, o_busy, o_out_valid);
        end
        cyc();
    endtask

    task automatic test_ignored_start();
        i_out_ready = 1'b0;
        do_start(2'd0, 8'h20, 16'd3);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h20) begin
            n_errors++;
            $display("FAIL ign_first: valid=%b data=%h, required 1 / 20", o_out_valid, o_out_data);
        end
        // New request mid-run, in the same cycle as the first beat.
        i_out_ready = 1'b1;
        do_start(2'd3, 8'h99, 16'd1);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h21 || o_count !== 16'd1) begin
            n_errors++;
            $display("FAIL ign_second: valid=%b data=%h count=%0d, required 1 / 21 / 1",
                     o_out_valid, o_out_data, o_count);
        end
        cyc();
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h22) begin
            n_errors++;
            $display("FAIL ign_third: valid=%b data=%h, required 1 / 22", o_out_valid, o_out_data);
        end
        cyc();
        n_checks++;
        if (o_done !== 1'b1 || o_count !== 16'd3) begin
            n_errors++;
            $display("FAIL ign_done: done=%b count=%0d, required 1/3", o_done, o_count);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        i_out_ready = 1'b1;
        do_start(2'd0, 8'h40, 16'd1);
        cyc();
        n_checks++;
        if (o_done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_done: done=%b, required 1", o_done);
        end
        cyc();
        // First IDLE cycle: start is accepted immediately.
        do_start(2'd0, 8'h50, 16'd2);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h50 || o_count !== 16'd0) begin
            n_errors++;
            $display("FAIL b2b_restart: valid=%b data=%h count=%0d, required 1 / 50 / 0",
                     o_out_valid, o_out_data, o_count);
        end
        repeat (2) cyc();
        n_checks++;
        if (o_done !== 1'b1 || o_count !== 16'd2) begin
            n_errors++;
            $display("FAIL b2b_second_done: done=%b count=%0d, required 1/2", o_done, o_count);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_increment();
        test_backpressure();
        test_lfsr();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised stimulus source that drives a valid/ready stream of DATA_W-bit words in one of four pattern modes for a programmed beat count. It generalises our fixed single-bit test generators into a reusable producer for simulation benches and on-chip self-test. It sits upstream of any consumer block under test and signals completion to the controlling logic or bench.

## Interface
- DATA_W, 8: width of generated data word (≥ 2)
- LEN_W, 16: width of beat-count fields
- LFSR_POLY, 8'hB8: Galois LFSR feedback mask, DATA_W bits
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE
- mode  in  2  pattern select: 0 increment, 1 rotate-left, 2 LFSR, 3 constant
- seed  in  DATA_W  first data word of the run
- len  in  LEN_W  number of beats to emit
- out_data  out  DATA_W  current word
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word this cycle
- busy  out  1  high while state is RUN or DONE
- done  out  1  one-cycle pulse at end of run
- count  out  LEN_W  beats accepted in the current/last run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start, latch mode, seed, len; clear count; out_data <= seed (LFSR mode: seed 0 replaced by 1). len != 0 -> RUN; len == 0 -> DONE with no beats.
- RUN: out_valid = 1. Beat = out_valid & out_ready. On beat: count += 1, out_data <= next(out_data). On the beat where count+1 == len -> DONE, out_valid drops.
- DONE: done = 1 for exactly one cycle, then IDLE.
- next(): mode 0: d+1 modulo 2^DATA_W (0xFF -> 0x00); mode 1: rotate left by 1 (0x81 -> 0x03); mode 2: lsb ? (d>>1)^LFSR_POLY : d>>1; mode 3: d.
- out_data stays stable while out_valid & !out_ready; no word is dropped or duplicated.
- start outside IDLE is ignored; latched mode/seed/len do not change mid-run.
- count holds its final value after the run until the next accepted start.

## Timing
- Reset values: out_data 0, out_valid 0, busy 0, done 0, count 0, state IDLE. Reset mid-run aborts immediately; no done pulse is issued.
- start at cycle n -> out_valid = 1 and out_data = seed at n+1.
- With out_ready held high: one beat per cycle, final beat at n+len, done at n+len+1, busy low at n+len+2.
- len == 0: done at n+1, busy high for n+1 only, out_valid never asserts.
- The next start is accepted in the first IDLE cycle (n+len+2 at the earliest).
- out_ready has no effect unless out_valid is high; no combinational path from out_ready to out_valid.

## Configuration
- PATTERN_GEN_LFSR_EN defined: mode 2 is the Galois LFSR described above.
- Not defined: LFSR logic is removed, LFSR_POLY is unused, mode 2 behaves exactly as mode 0 (increment), and seed 0 is used unaltered.

## Test plan
- Reset mid-run: mode 0, len 10, assert rst_n low after 3 beats -> all outputs 0 the same cycle, no done pulse, state IDLE after release.
- Increment with wrap: mode 0, seed 8'hFE, len 4, ready high -> 0xFE, 0xFF, 0x00, 0x01; done at n+5, count 4.
- Back-pressure: mode 1, seed 8'h81, len 3, ready toggling 1,0,0,1,1 -> 0x81, 0x03 (held 3 cycles), 0x06; no loss or duplication; count 3.
- LFSR: macro defined, mode 2, seed 0, len 6 -> 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3; macro undefined, same stimulus -> 0x00..0x05.
- Zero length and ignored start: len 0 -> done at n+1, out_valid stays 0; start pulsed mid-run with a new seed -> current run is unaffected.
